// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: per-register pending-writer counters that stall decode on RAW hazards until writeback commits.
module id_hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_WD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_valid,
  input  logic [4:0]  ds_rj,
  input  logic        ds_rj_used,
  input  logic [4:0]  ds_rkd,
  input  logic        ds_rkd_used,
  input  logic        ds_gr_we,
  input  logic [4:0]  ds_dest,
  input  logic        ds_issue,
  input  logic        ws_retire,
  input  logic        ws_gr_we,
  input  logic [4:0]  ws_dest,
  output logic        ds_ready_go,
  output logic [31:0] busy_vec,
  output logic [31:0] stall_cnt,
  output logic        sb_err
);
  logic [CNT_WD-1:0] w_cnt [32];
  logic [31:0] w_ovf, w_unf;
  logic w_inc, w_dec, w_same, w_hj, w_hk;
  assign w_inc = ds_issue && ds_gr_we && ds_dest != 5'd0;
  assign w_dec = ws_retire && ws_gr_we && ws_dest != 5'd0;
  assign w_same = w_inc && w_dec && ds_dest == ws_dest;
  assign w_hj = ds_rj_used && ds_rj != 5'd0 && w_cnt[ds_rj] != '0;
  assign w_hk = ds_rkd_used && ds_rkd != 5'd0 && w_cnt[ds_rkd] != '0;
  assign ds_ready_go = !(ds_valid && (w_hj || w_hk));
  assign w_cnt[0] = '0;
  assign w_ovf[0] = 1'b0;
  assign w_unf[0] = 1'b0;
  assign busy_vec[0] = 1'b0;
  genvar g;
  generate
    for (g = 1; g < 32; g++) begin : g_reg
      logic [CNT_WD-1:0] r_cnt;
      logic w_i, w_d;
      // A matched issue/retire on the same register cancels out.
      assign w_i = w_inc && ds_dest == 5'(g) && !w_same;
      assign w_d = w_dec && ws_dest == 5'(g) && !w_same;
      assign w_ovf[g] = w_i && r_cnt == CNT_WD'(MAX_INFLIGHT);
      assign w_unf[g] = w_d && r_cnt == '0;
      assign w_cnt[g] = r_cnt;
      assign busy_vec[g] = r_cnt != '0;
      always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else if (w_i && !w_ovf[g]) r_cnt <= r_cnt + 1'b1;
        else if (w_d && !w_unf[g]) r_cnt <= r_cnt - 1'b1;
      end
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      sb_err <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, ds_valid && !ds_ready_go};
      sb_err <= sb_err || (|w_ovf) || (|w_unf);
    end
  end
endmodule
